truth_table_capture: RTL and testbench
======================================

TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, cycles each input vector is held before s1 is sampled; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a full 16-vector sweep.
REQ-005 abort  input  1  terminate a sweep in progress.
REQ-006 expected  input  16  golden truth table; bit i = expected s1 for vector i.
REQ-007 s1  input  1  response of the combinational circuit under test.
REQ-008 a, b, c, d  output  1 each  stimulus to the circuit; {a,b,c,d} = vector index, a = MSB.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until the next accepted start.
REQ-011 table_out  output  16  captured truth table; bit i = s1 sampled for vector i.
REQ-012 mismatch  output  1  valid while done is high; 1 when table_out differs from expected.

Function
REQ-013 FSM states: IDLE, DRIVE, DONE; every output registered.
REQ-014 IDLE: start=1 at an edge -> DRIVE; vector=0, hold count=0, table_out cleared to 0, busy=1, done=0.
REQ-015 DRIVE: vector held stable for exactly HOLD_CYCLES cycles; the hold counter increments every cycle.
REQ-016 At the edge where the hold count equals HOLD_CYCLES-1: table_out[vector] <= s1, hold count <= 0, vector <= vector+1.
REQ-017 Sampling vector 15 -> DONE at that same edge; busy=0, done=1, mismatch <= (table_out with bit 15 updated != expected).
REQ-018 Latency: done rises exactly 16*HOLD_CYCLES cycles after the edge that accepted start.
REQ-019 start while in DRIVE is ignored; it causes no restart and no change to the sweep.
REQ-020 DONE: outputs hold; start=1 -> DRIVE as in REQ-014 (done falls, table_out cleared).
REQ-021 abort=1 in DRIVE -> IDLE next edge; a,b,c,d=0, busy=0, done=0, mismatch=0; table_out keeps the bits already sampled.
REQ-022 abort and the vector-15 sample edge coincide: abort wins; the state goes to IDLE and done is not asserted.
REQ-023 abort and start together in IDLE or DONE: abort wins; the state goes to or stays IDLE.
REQ-024 The vector counter is 4 bits wide and never wraps inside a sweep; the sweep ends after index 15.

Reset
REQ-025 rst_n low -> immediately: state IDLE; a,b,c,d=0; busy=0; done=0; mismatch=0; table_out=0; counters=0.
REQ-026 Reset asserted mid-sweep discards the sweep; no done pulse after release.
REQ-027 First start is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package tt_pkg holds: the state enum (IDLE, DRIVE, DONE), VEC_W=4, N_VEC=16.
REQ-029 One sub-module, hold_timer: clear, enable, terminal-count output at HOLD_CYCLES-1.
REQ-030 table_out is stored in a single 16-bit register indexed by the vector counter.

Verification
REQ-031 Circuit model s1=a&b&c&d, expected=16'h8000, HOLD_CYCLES=4, pulse start -> a,b,c,d step 0..15 every 4 cycles; done at +64 cycles; table_out=16'h8000; mismatch=0.
REQ-032 Same model, expected=16'h8001 -> table_out=16'h8000, mismatch=1.
REQ-033 Model s1=a^b^c^d, HOLD_CYCLES=2 -> done at +32 cycles; table_out=16'h6996.
REQ-034 abort asserted during vector 5 -> IDLE next edge; busy=0, done=0; table_out[4:0] retained, bits 15:5 = 0.
REQ-035 rst_n pulsed low mid-sweep (vector 9) -> all outputs 0 immediately; no done; a fresh start then sweeps from vector 0.
REQ-036 start pulsed again during DRIVE at vector 3 -> sweep unchanged; done still at +64 cycles from the first start.

Source files
------------

// File: rtl/tt_pkg.sv
// -----------------------------------------------------------------------------
// tt_pkg
// Shared definitions for the truth-table capture block:
//   state_e   - sweep controller states (IDLE, DRIVE, DONE)
//   VEC_W     - width of the stimulus vector index {a,b,c,d}
//   N_VEC     - number of vectors in a full sweep
//   LAST_VEC  - index of the final vector in a sweep
//   put_bit() - returns a table with one bit replaced
// -----------------------------------------------------------------------------
package tt_pkg;

  localparam int VEC_W = 4;
  localparam int N_VEC = 16;
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Replace bit idx of tbl with val.
  function automatic logic [N_VEC-1:0] put_bit(input logic [N_VEC-1:0] tbl,
                                               input logic [VEC_W-1:0] idx,
                                               input logic             val);
    logic [N_VEC-1:0] res;
    res      = tbl;
    res[idx] = val;
    return res;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Counts the cycles a stimulus vector has been held. The count restarts at 0
// on clear_i, and after reaching HOLD_CYCLES-1 while enabled it wraps to 0.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset
//   clear_i  - force count to 0 (takes priority over enable)
//   enable_i - advance the count this cycle
//   tc_o     - terminal count: count equals HOLD_CYCLES-1
// -----------------------------------------------------------------------------
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc_o = (count_q == TC_VAL);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/truth_table_capture.sv
// -----------------------------------------------------------------------------
// truth_table_capture
// Sweeps a 4-input combinational circuit through all 16 input vectors, holds
// each vector for HOLD_CYCLES cycles, samples the circuit response at the end
// of each hold and compares the captured table with a golden table.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   start      - request a full sweep (accepted in IDLE or DONE)
//   abort      - terminate a sweep; wins over start and over the final sample
//   expected   - golden table, bit i = expected s1 for vector i
//   s1         - response of the circuit under test
//   a,b,c,d    - stimulus, {a,b,c,d} = vector index
//   busy       - sweep in progress
//   done       - sweep completed, held until next accepted start
//   table_out  - captured table, bit i = s1 sampled for vector i
//   mismatch   - table_out differs from expected (valid while done)
// -----------------------------------------------------------------------------
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_VEC-1:0] expected,
  input  logic             s1,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic             mismatch
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [N_VEC-1:0] table_q, table_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;

  logic             tmr_clear;
  logic             tmr_en;
  logic             tmr_tc;
  logic [N_VEC-1:0] table_sampled;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .tc_o     (tmr_tc)
  );

  // Table as it will look once the current vector's response is written.
  assign table_sampled = put_bit(table_q, vec_q, s1);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    table_d    = table_q;
    busy_d     = busy_q;
    done_d     = done_q;
    mismatch_d = mismatch_q;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          // Abort has priority over start; leaving DONE drops the result flags.
          state_d    = IDLE;
          vec_d      = '0;
          busy_d     = 1'b0;
          done_d     = 1'b0;
          mismatch_d = 1'b0;
          tmr_clear  = 1'b1;
        end else if (start) begin
          state_d    = DRIVE;
          vec_d      = '0;
          table_d    = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          mismatch_d = 1'b0;
          tmr_clear  = 1'b1;
        end
      end

      DRIVE: begin
        tmr_en = 1'b1;
        if (abort) begin
          // Already sampled bits are kept for inspection.
          state_d    = IDLE;
          vec_d      = '0;
          busy_d     = 1'b0;
          done_d     = 1'b0;
          mismatch_d = 1'b0;
          tmr_clear  = 1'b1;
        end else if (tmr_tc) begin
          table_d = table_sampled;
          if (vec_q == LAST_VEC) begin
            // Vector index stays at the last value rather than wrapping.
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            mismatch_d = (table_sampled != expected);
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        vec_d      = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mismatch_d = 1'b0;
        tmr_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      table_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      table_q    <= table_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign mismatch     = mismatch_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// -----------------------------------------------------------------------------
// tb_truth_table_capture
// Two instances: dut4 (HOLD_CYCLES=4, circuit selectable AND/XOR) and
// dut2 (HOLD_CYCLES=2, XOR circuit). Expected sweep results go into a
// scoreboard queue when start is driven and are compared when done rises.
// -----------------------------------------------------------------------------
module tb_truth_table_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start4, abort4, start2, abort2;
  logic        xor4;
  logic [15:0] exp4, exp2;

  logic        a4, b4, c4, d4, busy4, done4, mm4;
  logic [15:0] tbl4;
  logic        a2, b2, c2, d2, busy2, done2, mm2;
  logic [15:0] tbl2;
  logic        s1_4, s1_2;

  // Circuits under test.
  assign s1_4 = xor4 ? (a4 ^ b4 ^ c4 ^ d4) : (a4 & b4 & c4 & d4);
  assign s1_2 = a2 ^ b2 ^ c2 ^ d2;

  truth_table_capture #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .expected(exp4), .s1(s1_4), .a(a4), .b(b4), .c(c4), .d(d4),
    .busy(busy4), .done(done4), .table_out(tbl4), .mismatch(mm4)
  );

  truth_table_capture #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .expected(exp2), .s1(s1_2), .a(a2), .b(b2), .c(c2), .d(d2),
    .busy(busy2), .done(done2), .table_out(tbl2), .mismatch(mm2)
  );

  typedef struct {
    logic [15:0] tbl;
    logic        mm;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Reference truth table of the selected circuit.
  function automatic logic [15:0] model_tbl(input bit use_xor);
    logic [15:0] t;
    logic [3:0]  idx;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      idx  = i[3:0];
      t[i] = use_xor ? ^idx : &idx;
    end
    return t;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 2) start2 = v;
    else          start4 = v;
  endtask

  // Called at a negedge. restart_at >= 0 pulses start again after that edge.
  task automatic run_sweep(input int sel, input int restart_at);
    exp_t        e;
    exp_t        got;
    int          h;
    int          k;
    logic [15:0] t;
    h     = (sel == 2) ? 2 : 4;
    t     = (sel == 2) ? model_tbl(1'b1) : model_tbl(xor4);
    e.tbl = t;
    e.mm  = (t != ((sel == 2) ? exp2 : exp4));
    e.lat = 16 * h;
    sb_q.push_back(e);

    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    k = 0;
    while (!((sel == 2) ? done2 : done4) && k < 300) begin
      if (k < 16 * h) begin
        check("vector", (sel == 2) ? {a2, b2, c2, d2} : {a4, b4, c4, d4}, k / h);
        check("busy",   (sel == 2) ? busy2 : busy4, 1'b1);
      end
      if (restart_at >= 0) set_start(sel, k == restart_at);
      @(negedge clk);
      k++;
    end
    set_start(sel, 1'b0);

    got = sb_q.pop_front();
    check("latency",   k, got.lat);
    check("table_out", (sel == 2) ? tbl2 : tbl4, got.tbl);
    check("mismatch",  (sel == 2) ? mm2 : mm4, got.mm);
    check("busy_done", (sel == 2) ? busy2 : busy4, 1'b0);
    $display("sweep hold=%0d table=%h mismatch=%b latency=%0d", h,
             (sel == 2) ? tbl2 : tbl4, (sel == 2) ? mm2 : mm4, k);
  endtask

  task automatic check_idle4(input string tag);
    check({tag, "_busy"}, busy4, 1'b0);
    check({tag, "_done"}, done4, 1'b0);
    check({tag, "_mm"},   mm4, 1'b0);
    check({tag, "_vec"},  {a4, b4, c4, d4}, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start4 = 1'b0; abort4 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    xor4   = 1'b0;
    exp4   = 16'h8000;
    exp2   = 16'h6996;

    // Reset values.
    #12;
    check_idle4("rst");
    check("rst_table4", tbl4, 16'h0);
    check("rst_table2", tbl2, 16'h0);
    check("rst_done2",  done2, 1'b0);
    $display("reset state sampled");

    // Start on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(4, -1);

    // Outputs hold in DONE.
    repeat (3) @(negedge clk);
    check("hold_done",  done4, 1'b1);
    check("hold_table", tbl4, 16'h8000);

    // Golden table differs -> mismatch; also start from DONE.
    exp4 = 16'h8001;
    run_sweep(4, -1);

    // XOR circuit, shorter hold.
    run_sweep(2, -1);

    // Second start during vector 3 is ignored.
    exp4 = 16'h8000;
    run_sweep(4, 12);

    // Abort during vector 5.
    xor4   = 1'b1;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (21) @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check_idle4("abort");
    check("abort_table", tbl4, model_tbl(1'b1) & 16'h001F);
    repeat (80) @(negedge clk);
    check("abort_nodone", done4, 1'b0);
    check("abort_keep",   tbl4, model_tbl(1'b1) & 16'h001F);
    $display("abort at vector 5 table=%h", tbl4);

    // Abort on the vector-15 sample edge.
    xor4   = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (63) @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check_idle4("abort15");
    check("abort15_table", tbl4, 16'h0000);
    $display("abort on last sample table=%h", tbl4);

    // Start and abort together in IDLE.
    start4 = 1'b1; abort4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; abort4 = 1'b0;
    repeat (2) @(negedge clk);
    check_idle4("sa_idle");

    // Start and abort together in DONE.
    xor4 = 1'b1;
    run_sweep(4, -1);
    start4 = 1'b1; abort4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; abort4 = 1'b0;
    repeat (2) @(negedge clk);
    check_idle4("sa_done");
    $display("start+abort in IDLE and DONE handled");

    // Reset mid-sweep at vector 9.
    xor4   = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle4("midrst");
    check("midrst_table", tbl4, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("midrst_nodone", done4, 1'b0);
    check("midrst_nobusy", busy4, 1'b0);
    $display("reset mid-sweep discarded");
    run_sweep(4, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
